// File: rtl/rf_pkg.sv
// Constants and types shared by the register file and its write-side arbiter.
package rf_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx
);

  logic found;

  // Outer loop walks the distance from ptr so the nearest request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] &&
            ((int'(ptr) + k == i) || (int'(ptr) + k == i + N))) begin
          grant[i]  = 1'b1;
          grant_idx = PTR_W'(i);
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port among N_REQ writeback sources with a
// registered output stage; writes aimed at x0 are accepted but never presented.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [REG_ADDR_W*N_REQ-1:0]   req_addr,
  input  logic [XLEN*N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          wr_ena,
  output logic [REG_ADDR_W-1:0]         wr_addr,
  output logic [XLEN-1:0]               wr_data,
  output logic                          contention,
  output logic [CNT_W-1:0]              x0_drops
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  wb_req_t            reqs [N_REQ];
  wb_req_t            sel;
  logic [N_REQ-1:0]   req_gated;
  logic [N_REQ-1:0]   grant;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   rr_ptr;
  logic               transfer;
  logic               multi_valid;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      reqs[i].addr = req_addr[REG_ADDR_W*i +: REG_ADDR_W];
      reqs[i].data = req_data[XLEN*i +: XLEN];
    end
  end

  // Reset and stall both suppress grants so no transfer can occur in those cycles.
  assign req_gated   = (stall || rst) ? '0 : req_valid;
  assign req_ready   = grant;
  assign transfer    = |grant;
  assign sel         = reqs[grant_idx];
  assign multi_valid = ($countones(req_valid) >= 2);

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req       (req_gated),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      wr_ena     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      contention <= 1'b0;
      x0_drops   <= '0;
    end else begin
      contention <= multi_valid && !stall;
      if (transfer) begin
        wr_addr <= sel.addr;
        wr_data <= sel.data;
        wr_ena  <= (sel.addr != X0_ADDR);
        rr_ptr  <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        if ((sel.addr == X0_ADDR) && (x0_drops != '1))
          x0_drops <= x0_drops + 1'b1;
      end else begin
        wr_ena <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed and randomized checks of rf_write_arbiter against a cycle-level reference model.
module tb_rf_write_arbiter;

  localparam int N     = 3;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic [N-1:0]     req_valid;
  logic [5*N-1:0]   req_addr;
  logic [32*N-1:0]  req_data;
  logic [N-1:0]     req_ready;
  logic             wr_ena;
  logic [4:0]       wr_addr;
  logic [31:0]      wr_data;
  logic             contention;
  logic [CNT_W-1:0] x0_drops;

  int tests = 0;
  int fails = 0;

  logic [4:0]  a_addr [N];
  logic [31:0] a_data [N];

  int          m_ptr;
  logic        m_ena;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_cont;
  int          m_cnt;
  int          last_g;
  bit          pending [N];

  rf_write_arbiter #(.N_REQ(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wr_ena     (wr_ena),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .contention (contention),
    .x0_drops   (x0_drops)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < N; i++) begin
      req_addr[5*i +: 5]   = a_addr[i];
      req_data[32*i +: 32] = a_data[i];
    end
  endtask

  // Nearest valid requester at or after the model pointer, or -1 when nothing may be granted.
  function automatic int model_grant();
    int best  = -1;
    int bestd = N;
    if (rst || stall) return -1;
    for (int i = 0; i < N; i++) begin
      int d = (i - m_ptr + N) % N;
      if (req_valid[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic applyStimulus(input string tag, output int g);
    logic [N-1:0] er;
    pack_inputs();
    #1;
    g  = model_grant();
    er = (g < 0) ? '0 : N'(1) << g;
    chk({tag, "/req_ready"}, 64'(req_ready), 64'(er));
    @(posedge clk);
    #1;
    if (rst) begin
      m_ptr = 0; m_ena = 0; m_addr = 0; m_data = 0; m_cont = 0; m_cnt = 0;
    end else begin
      m_cont = ($countones(req_valid) >= 2) && !stall;
      if (g >= 0) begin
        m_ptr  = (g + 1) % N;
        m_addr = a_addr[g];
        m_data = a_data[g];
        m_ena  = (a_addr[g] != 0);
        if (a_addr[g] == 0 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end else begin
        m_ena = 0;
      end
    end
    checkOutput(tag);
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, "/wr_ena"},     64'(wr_ena),     64'(m_ena));
    chk({tag, "/wr_addr"},    64'(wr_addr),    64'(m_addr));
    chk({tag, "/wr_data"},    64'(wr_data),    64'(m_data));
    chk({tag, "/contention"}, 64'(contention), 64'(m_cont));
    chk({tag, "/x0_drops"},   64'(x0_drops),   64'(m_cnt));
  endtask

  initial begin
    int g;
    logic [N-1:0] exp_grants [6];

    rst = 1; stall = 0; req_valid = '1;
    for (int i = 0; i < N; i++) begin
      a_addr[i] = 5'(i + 7);
      a_data[i] = 32'hA000_0000 + 32'(i);
    end
    m_ptr = 0; m_ena = 0; m_addr = 0; m_data = 0; m_cont = 0; m_cnt = 0;

    // Reset with every requester valid
    for (int c = 0; c < 2; c++) applyStimulus("reset", g);
    chk("reset/wr_ena_const",   64'(wr_ena),   64'd0);
    chk("reset/wr_addr_const",  64'(wr_addr),  64'd0);
    chk("reset/x0_drops_const", 64'(x0_drops), 64'd0);

    // Fairness between requesters 0 and 1
    rst = 0; req_valid = 3'b011;
    exp_grants = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("fair/grant_const", 64'(req_ready), 64'(exp_grants[c]));
      applyStimulus("fair", g);
      chk("fair/contention_const", 64'(contention), 64'd1);
    end

    // Single requester, address 5
    req_valid = 3'b001; a_addr[0] = 5'd5; a_data[0] = 32'hDEADBEEF;
    applyStimulus("single", g);
    chk("single/wr_ena_const",  64'(wr_ena),  64'd1);
    chk("single/wr_addr_const", 64'(wr_addr), 64'd5);
    chk("single/wr_data_const", 64'(wr_data), 64'hDEADBEEF);
    req_valid = '0;
    applyStimulus("single_idle", g);
    chk("single/wr_ena_low", 64'(wr_ena), 64'd0);

    // x0 write from requester 1
    req_valid = 3'b010; a_addr[1] = 5'd0; a_data[1] = 32'h1234;
    applyStimulus("x0", g);
    chk("x0/wr_ena_const",   64'(wr_ena),   64'd0);
    chk("x0/x0_drops_const", 64'(x0_drops), 64'd1);

    // Accept, then stall three cycles, then release
    req_valid = 3'b011; a_addr[0] = 5'd9; a_addr[1] = 5'd10;
    applyStimulus("pre_stall", g);
    stall = 1;
    chk("stall/held_write", 64'(wr_ena), 64'd1);
    for (int c = 0; c < 3; c++) applyStimulus("stall", g);
    stall = 0;
    #1;
    chk("stall/first_grant", 64'(req_ready), 64'b010);
    applyStimulus("release", g);

    // Write accepted just before reset is lost
    req_valid = 3'b100; a_addr[2] = 5'd3;
    applyStimulus("pre_rst", g);
    rst = 1;
    applyStimulus("mid_rst", g);
    chk("mid_rst/wr_ena_const", 64'(wr_ena), 64'd0);
    rst = 0;

    // Counter saturation
    req_valid = 3'b001; a_addr[0] = 5'd0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus("sat", g);
      chk("sat/x0_drops_const", 64'(x0_drops), 64'((c < 3) ? c + 1 : 3));
    end

    // Randomized traffic obeying the hold-until-granted rule
    for (int i = 0; i < N; i++) pending[i] = 0;
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 99) < 3);
      stall = ($urandom_range(0, 99) < 20);
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
          pending[i] = 1;
          a_addr[i]  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          a_data[i]  = $urandom;
        end
        req_valid[i] = pending[i];
      end
      applyStimulus("rand", last_g);
      if (last_g >= 0) pending[last_g] = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
